mini_core_fetch: RTL



---
 rtl/mini_core_fetch_pkg.sv | 17 +
 rtl/mini_core_fetch_if.sv | 20 ++
 rtl/mini_core_fetch_iq.sv | 72 +++++++
 rtl/mini_core_fetch.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mini_core_fetch_pkg.sv
// Shared types and constants for the mini core fetch stage: queue entry
// layout, default queue depth, the canonical NOP and a word-align helper.
package mini_core_fetch_pkg;

   localparam logic [31:0] NOP            = 32'h0000_0013;
   localparam int          FETCH_IQ_DEPTH = 2;

   typedef struct packed {
      logic [31:0] Pc;
      logic [31:0] Instruction;
   } t_fetch_entry;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mini_core_fetch_if.sv
// Instruction-memory request/response bundle between fetch (master) and IMem (slave).
interface mini_core_fetch_if;

   logic        IMemReqValid;
   logic        IMemReqReady;
   logic [31:0] IMemAddr;
   logic        IMemRspValid;
   logic [31:0] IMemRspData;

   modport master (
      output IMemReqValid, IMemAddr,
      input  IMemReqReady, IMemRspValid, IMemRspData
   );

   modport slave (
      input  IMemReqValid, IMemAddr,
      output IMemReqReady, IMemRspValid, IMemRspData
   );

endinterface

// File: rtl/mini_core_fetch_iq.sv
// Synchronous FIFO of fetch entries with flush; used as the instruction queue
// and as the issued-PC shadow queue. DEPTH must be a power of two, >= 2.
module mini_core_fetch_iq
   import mini_core_fetch_pkg::*;
#(
   parameter  int DEPTH = FETCH_IQ_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          Clock,
   input  logic          RstN,
   input  logic          push_i,
   input  t_fetch_entry  push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output t_fetch_entry  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   t_fetch_entry  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full queue is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge RstN) begin
      if (!RstN) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/mini_core_fetch.sv
// Q100H instruction fetch: owns the PC, issues credit-limited IMem requests,
// queues responses for decode and drops wrong-path data after a redirect.
// Optional macro MINI_CORE_FETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect flag.
module mini_core_fetch
   import mini_core_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IQ_DEPTH = FETCH_IQ_DEPTH
) (
   input  logic                     Clock,
   input  logic                     RstN,
   input  logic                     ReadyQ101H,
   input  logic                     SelNextPcAluOutQ102H,
   input  logic [31:0]              AluOutQ102H,
   mini_core_fetch_if.master        imem,
   output logic [31:0]              PreInstructionQ101H,
   output logic [31:0]              PcQ101H,
   output logic                     FetchValidQ101H
`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
   ,
   output logic                     FetchMisalignErr,
   output logic [31:0]              FetchMisalignAddr
`endif
);

   localparam int CW = $clog2(IQ_DEPTH) + 1;

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [31:0]   pc_hold_q;

   t_fetch_entry  q_head, q_push_data;
   logic [CW-1:0] q_count;
   logic          q_full, q_empty;
   t_fetch_entry  sh_head, sh_push_data;
   logic [CW-1:0] sh_count;
   logic          sh_full, sh_empty;

   logic          redirect, rsp_accept, rsp_keep, pop, req_valid, req_fire;
   logic [CW:0]   credit_used;

   assign redirect   = SelNextPcAluOutQ102H;
   assign rsp_accept = imem.IMemRspValid && !sh_empty;
   assign rsp_keep   = rsp_accept && !redirect && (drop_cnt_q == '0);
   assign pop        = ReadyQ101H && !q_empty;

   // A slot vacated by this cycle's pop already counts as credit, so a
   // single-cycle IMem sustains one instruction per cycle.
   assign credit_used = {1'b0, q_count} + {1'b0, sh_count} - {{CW{1'b0}}, pop};
   assign req_valid   = RstN && !redirect && (credit_used < (CW+1)'(IQ_DEPTH));
   assign req_fire    = req_valid && imem.IMemReqReady;

   assign imem.IMemReqValid = req_valid;
   assign imem.IMemAddr     = pc_q;

   assign q_push_data.Pc           = sh_head.Pc;
   assign q_push_data.Instruction  = imem.IMemRspData;
   assign sh_push_data.Pc          = pc_q;
   assign sh_push_data.Instruction = '0;

   mini_core_fetch_iq #(.DEPTH(IQ_DEPTH)) u_iq (
      .Clock       (Clock),
      .RstN        (RstN),
      .push_i      (rsp_keep),
      .push_data_i (q_push_data),
      .pop_i       (pop),
      .flush_i     (redirect),
      .head_o      (q_head),
      .count_o     (q_count),
      .full_o      (q_full),
      .empty_o     (q_empty)
   );

   // Shadow of issued PCs; its occupancy is the outstanding-request count.
   mini_core_fetch_iq #(.DEPTH(IQ_DEPTH)) u_pc_shadow (
      .Clock       (Clock),
      .RstN        (RstN),
      .push_i      (req_fire),
      .push_data_i (sh_push_data),
      .pop_i       (rsp_accept),
      .flush_i     (1'b0),
      .head_o      (sh_head),
      .count_o     (sh_count),
      .full_o      (sh_full),
      .empty_o     (sh_empty)
   );

   always_comb begin
      pc_d       = pc_q;
      drop_cnt_d = drop_cnt_q;
      if (redirect) begin
         pc_d       = word_align(AluOutQ102H);
         drop_cnt_d = sh_count - CW'(rsp_accept);
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         if (rsp_accept && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge RstN) begin
      if (!RstN) begin
         pc_q       <= RESET_PC;
         drop_cnt_q <= '0;
         pc_hold_q  <= RESET_PC;
      end else begin
         pc_q       <= pc_d;
         drop_cnt_q <= drop_cnt_d;
         pc_hold_q  <= PcQ101H;
      end
   end

   assign FetchValidQ101H     = !q_empty;
   assign PreInstructionQ101H = q_empty ? NOP : q_head.Instruction;
   assign PcQ101H             = q_empty ? pc_hold_q : q_head.Pc;

`ifdef MINI_CORE_FETCH_MISALIGN_CHK_EN
   logic        mis_err_q;
   logic [31:0] mis_addr_q;

   always_ff @(posedge Clock or negedge RstN) begin
      if (!RstN) begin
         mis_err_q  <= 1'b0;
         mis_addr_q <= '0;
      end else if (redirect && (AluOutQ102H[1:0] != 2'b00)) begin
         mis_err_q  <= 1'b1;
         mis_addr_q <= AluOutQ102H;
      end
   end

   assign FetchMisalignErr  = mis_err_q;
   assign FetchMisalignAddr = mis_addr_q;
`endif

   logic unused_sig;
   assign unused_sig = ^{sh_head.Instruction, q_full, sh_full};

endmodule
